// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared widths, scan-result record and count encodings for the 5x4 keypad scanner.
package keypad_pkg;

    localparam int ROWS   = 5;
    localparam int COLS   = 4;
    localparam int CODE_W = 5;

    localparam logic [1:0] CNT_NONE  = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_MULTI = 2'd2;

    typedef struct packed {
        logic [1:0]        cnt;
        logic [CODE_W-1:0] code;
    } scan_result_t;

    // Key count accumulation saturates at "two or more"
    function automatic logic [1:0] sat_add(input logic [1:0] a, input logic [2:0] b);
        logic [3:0] s;
        s = {2'b00, a} + {1'b0, b};
        return (s >= 4'd2) ? CNT_MULTI : s[1:0];
    endfunction

endpackage

// File: rtl/keypad_scan_debounce.sv
// Whole-scan debouncer: commits a scan result once it repeats DEBOUNCE_SCANS times in a row.
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic              clk,
    input  logic              RSTN,
    input  logic              scan_done_i,
    input  scan_result_t      result_i,
    output logic [CODE_W-1:0] key_code_o,
    output logic              key_pressed_o,
    output logic              key_pulse_o,
    output logic              multi_key_o
);

    localparam int STW = (DEBOUNCE_SCANS < 2) ? 1 : $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [STW-1:0] STABLE_MAX = STW'(DEBOUNCE_SCANS);

    scan_result_t      prev_q, prev_d;
    logic [STW-1:0]    stable_q, stable_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              pressed_q, pressed_d;
    logic              pulse_q, pulse_d;
    logic              multi_q, multi_d;

    logic same;
    logic saturated;
    logic commit;

    always_comb begin
        prev_d    = prev_q;
        stable_d  = stable_q;
        code_d    = code_q;
        pressed_d = pressed_q;
        multi_d   = multi_q;
        pulse_d   = 1'b0;
        commit    = 1'b0;
        same      = (result_i == prev_q);
        saturated = (stable_q == STABLE_MAX);

        if (scan_done_i) begin
            prev_d = result_i;
            if (same) begin
                stable_d = saturated ? stable_q : stable_q + 1'b1;
            end else begin
                stable_d = STW'(1);
            end
            // A result that is already committed and unchanged must not recommit
            commit = (stable_d == STABLE_MAX) && !(same && saturated);
        end

        if (commit) begin
            case (result_i.cnt)
                CNT_NONE: begin
                    pressed_d = 1'b0;
                    multi_d   = 1'b0;
                end
                CNT_ONE: begin
                    code_d    = result_i.code;
                    pressed_d = 1'b1;
                    multi_d   = 1'b0;
                    pulse_d   = !pressed_q || (code_q != result_i.code);
                end
                default: begin
                    pressed_d = 1'b0;
                    multi_d   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            prev_q    <= '0;
            stable_q  <= '0;
            code_q    <= '0;
            pressed_q <= 1'b0;
            pulse_q   <= 1'b0;
            multi_q   <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            stable_q  <= stable_d;
            code_q    <= code_d;
            pressed_q <= pressed_d;
            pulse_q   <= pulse_d;
            multi_q   <= multi_d;
        end
    end

    assign key_code_o    = code_q;
    assign key_pressed_o = pressed_q;
    assign key_pulse_o   = pulse_q;
    assign multi_key_o   = multi_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 5x4 keypad matrix scanner: active-low row drive, column synchroniser, per-scan
// accumulation of key hits, and whole-scan debouncing of the decoded result.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 8,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic              clk,
    input  logic              RSTN,
    input  logic [COLS-1:0]   K_COL,
    output logic [ROWS-1:0]   K_ROW,
    output logic [CODE_W-1:0] key_code,
    output logic              key_pressed,
    output logic              key_pulse,
    output logic              multi_key
);

    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [2:0]    ROW_LAST    = 3'(ROWS - 1);

    logic [COLS-1:0]   col_meta_q, col_sync_q;
    logic [2:0]        row_q;
    logic [SW-1:0]     settle_q;
    logic [ROWS-1:0]   k_row_q;
    logic [1:0]        acc_cnt_q;
    logic [CODE_W-1:0] acc_code_q;
    scan_result_t      result_q;
    logic              scan_done_q;

    logic [COLS-1:0]   hits;
    logic [2:0]        hit_cnt;
    logic [1:0]        first_col;
    logic [1:0]        row_cnt;
    logic [CODE_W-1:0] row_code;
    logic              settle_last;
    logic              row_last;
    logic [2:0]        row_next;
    logic [ROWS-1:0]   k_row_next;

    assign hits        = ~col_sync_q;
    assign settle_last = (settle_q == SETTLE_LAST);
    assign row_last    = (row_q == ROW_LAST);
    assign row_next    = row_last ? 3'd0 : row_q + 3'd1;

    always_comb begin
        hit_cnt   = '0;
        first_col = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (hits[c]) begin
                first_col = 2'(c);
            end
        end
        for (int c = 0; c < COLS; c++) begin
            hit_cnt = hit_cnt + {2'b00, hits[c]};
        end
    end

    // Only the first hit of a scan (lowest row, then lowest column) names the code
    assign row_cnt  = sat_add(acc_cnt_q, hit_cnt);
    assign row_code = ((acc_cnt_q == CNT_NONE) && (hits != '0)) ? {row_q, first_col} : acc_code_q;

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_drive
            assign k_row_next[gi] = (row_next != 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            col_meta_q  <= '1;
            col_sync_q  <= '1;
            row_q       <= '0;
            settle_q    <= '0;
            k_row_q     <= 5'b11110;
            acc_cnt_q   <= CNT_NONE;
            acc_code_q  <= '0;
            result_q    <= '0;
            scan_done_q <= 1'b0;
        end else begin
            col_meta_q  <= K_COL;
            col_sync_q  <= col_meta_q;
            scan_done_q <= 1'b0;

            if (settle_last) begin
                settle_q <= '0;
                row_q    <= row_next;
                k_row_q  <= k_row_next;
                if (row_last) begin
                    result_q.cnt  <= row_cnt;
                    result_q.code <= row_code;
                    scan_done_q   <= 1'b1;
                    acc_cnt_q     <= CNT_NONE;
                    acc_code_q    <= '0;
                end else begin
                    acc_cnt_q  <= row_cnt;
                    acc_code_q <= row_code;
                end
            end else begin
                settle_q <= settle_q + 1'b1;
            end
        end
    end

    assign K_ROW = k_row_q;

    keypad_scan_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk          (clk),
        .RSTN         (RSTN),
        .scan_done_i  (scan_done_q),
        .result_i     (result_q),
        .key_code_o   (key_code),
        .key_pressed_o(key_pressed),
        .key_pulse_o  (key_pulse),
        .multi_key_o  (multi_key)
    );

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: a modelled key matrix, per-scenario tasks and a
// key-set reference model (count closed keys, first key in row-major order).
module tb_keypad_matrix_scanner;

    logic       clk = 1'b0;
    logic       RSTN;
    logic [3:0] K_COL;
    logic [4:0] K_ROW;
    logic [4:0] key_code;
    logic       key_pressed;
    logic       key_pulse;
    logic       multi_key;

    logic [19:0] keys = '0;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int pulse_wide = 0;
    logic pulse_prev = 1'b0;

    int exp_code = 0;
    bit exp_pressed = 0;
    bit exp_multi = 0;
    int exp_pulses = 0;

    always #5 clk = ~clk;

    keypad_matrix_scanner dut (
        .clk        (clk),
        .RSTN       (RSTN),
        .K_COL      (K_COL),
        .K_ROW      (K_ROW),
        .key_code   (key_code),
        .key_pressed(key_pressed),
        .key_pulse  (key_pulse),
        .multi_key  (multi_key)
    );

    // Closed key at (r,c) pulls column c low while row r is driven low
    always_comb begin
        K_COL = 4'hF;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !K_ROW[r]) K_COL[c] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (key_pulse) pulse_cnt <= pulse_cnt + 1;
        if (key_pulse && pulse_prev) pulse_wide <= pulse_wide + 1;
        pulse_prev <= key_pulse;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Reference: what a stable key set should commit, and how many pulses it yields
    task automatic model_apply(input logic [19:0] k);
        int cnt;
        int code;
        cnt = 0;
        code = 0;
        for (int i = 0; i < 20; i++) begin
            if (k[i]) begin
                if (cnt == 0) code = i;
                cnt++;
            end
        end
        exp_pulses = 0;
        if (cnt == 0) begin
            exp_pressed = 0;
            exp_multi = 0;
        end else if (cnt == 1) begin
            if (!exp_pressed || exp_code != code) exp_pulses = 1;
            exp_code = code;
            exp_pressed = 1;
            exp_multi = 0;
        end else begin
            exp_pressed = 0;
            exp_multi = 1;
        end
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        keys = '0;
        cycles(3);
        checks++; if (K_ROW !== 5'b11110) begin errors++; $display("FAIL reset_krow got %b want 11110", K_ROW); end
        checks++; if (key_code !== 5'd0) begin errors++; $display("FAIL reset_code got %0d want 0", key_code); end
        checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL reset_pressed got %b want 0", key_pressed); end
        checks++; if (key_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b want 0", key_pulse); end
        checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL reset_multi got %b want 0", multi_key); end
        $display("reset: K_ROW=%b code=%0d pressed=%b multi=%b", K_ROW, key_code, key_pressed, multi_key);
    endtask

    task automatic test_row_scan();
        logic [4:0] want;
        int bad;
        bad = 0;
        RSTN = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            want = ~(5'b00001 << ((k / 8) % 5));
            checks++;
            if (K_ROW !== want) begin
                errors++;
                bad++;
                if (bad < 5) $display("FAIL row_scan cycle %0d got %b want %b", k, K_ROW, want);
            end
        end
        $display("row_scan: 80 cycles, %0d deviations", bad);
    endtask

    task automatic test_single_press();
        int base;
        bit found;
        int lat;
        keys = '0;
        keys[9] = 1'b1;
        base = pulse_cnt;
        found = 0;
        lat = 0;
        for (int i = 1; i <= 163; i++) begin
            @(negedge clk);
            if (key_pulse) begin found = 1; lat = i; break; end
        end
        model_apply(keys);
        checks++; if (!found) begin errors++; $display("FAIL press_latency got none want pulse within 163 cycles"); end
        cycles(2);
        checks++; if (key_code !== 5'(exp_code)) begin errors++; $display("FAIL press_code got %0d want %0d", key_code, exp_code); end
        checks++; if (key_pressed !== exp_pressed) begin errors++; $display("FAIL press_level got %b want %b", key_pressed, exp_pressed); end
        checks++; if (multi_key !== exp_multi) begin errors++; $display("FAIL press_multi got %b want %b", multi_key, exp_multi); end
        cycles(200);
        checks++; if (pulse_cnt - base != exp_pulses) begin errors++; $display("FAIL press_pulses got %0d want %0d", pulse_cnt - base, exp_pulses); end
        $display("single_press: key 9 latency=%0d code=%0d pulses=%0d", lat, key_code, pulse_cnt - base);
    endtask

    task automatic test_release();
        int base;
        keys = '0;
        base = pulse_cnt;
        cycles(170);
        model_apply(keys);
        checks++; if (key_pressed !== exp_pressed) begin errors++; $display("FAIL release_level got %b want %b", key_pressed, exp_pressed); end
        checks++; if (key_code !== 5'(exp_code)) begin errors++; $display("FAIL release_code got %0d want %0d", key_code, exp_code); end
        checks++; if (multi_key !== exp_multi) begin errors++; $display("FAIL release_multi got %b want %b", multi_key, exp_multi); end
        checks++; if (pulse_cnt - base != exp_pulses) begin errors++; $display("FAIL release_pulses got %0d want %0d", pulse_cnt - base, exp_pulses); end
        $display("release: pressed=%b code=%0d pulses=%0d", key_pressed, key_code, pulse_cnt - base);
    endtask

    task automatic test_bounce();
        int base;
        base = pulse_cnt;
        for (int t = 0; t < 200; t++) begin
            keys[19] = ((t / 30) % 2 == 0);
            @(negedge clk);
        end
        #1;
        checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL bounce_nocommit got pressed=%b want 0", key_pressed); end
        checks++; if (pulse_cnt != base) begin errors++; $display("FAIL bounce_nopulse got %0d want 0", pulse_cnt - base); end
        keys = '0;
        keys[19] = 1'b1;
        cycles(170);
        model_apply(keys);
        checks++; if (key_code !== 5'(exp_code)) begin errors++; $display("FAIL bounce_code got %0d want %0d", key_code, exp_code); end
        checks++; if (key_pressed !== exp_pressed) begin errors++; $display("FAIL bounce_level got %b want %b", key_pressed, exp_pressed); end
        checks++; if (pulse_cnt - base != exp_pulses) begin errors++; $display("FAIL bounce_pulses got %0d want %0d", pulse_cnt - base, exp_pulses); end
        $display("bounce: code=%0d pressed=%b pulses=%0d", key_code, key_pressed, pulse_cnt - base);
    endtask

    task automatic test_multi_key();
        int base;
        keys = '0;
        keys[0] = 1'b1;
        keys[14] = 1'b1;
        base = pulse_cnt;
        cycles(170);
        model_apply(keys);
        checks++; if (multi_key !== exp_multi) begin errors++; $display("FAIL multi_flag got %b want %b", multi_key, exp_multi); end
        checks++; if (key_pressed !== exp_pressed) begin errors++; $display("FAIL multi_level got %b want %b", key_pressed, exp_pressed); end
        checks++; if (key_code !== 5'(exp_code)) begin errors++; $display("FAIL multi_code got %0d want %0d", key_code, exp_code); end
        checks++; if (pulse_cnt - base != exp_pulses) begin errors++; $display("FAIL multi_pulses got %0d want %0d", pulse_cnt - base, exp_pulses); end
        $display("multi: keys 0+14 multi=%b pressed=%b", multi_key, key_pressed);
        keys[14] = 1'b0;
        base = pulse_cnt;
        cycles(170);
        model_apply(keys);
        checks++; if (key_code !== 5'(exp_code)) begin errors++; $display("FAIL multi_rel_code got %0d want %0d", key_code, exp_code); end
        checks++; if (key_pressed !== exp_pressed) begin errors++; $display("FAIL multi_rel_level got %b want %b", key_pressed, exp_pressed); end
        checks++; if (multi_key !== exp_multi) begin errors++; $display("FAIL multi_rel_flag got %b want %b", multi_key, exp_multi); end
        checks++; if (pulse_cnt - base != exp_pulses) begin errors++; $display("FAIL multi_rel_pulses got %0d want %0d", pulse_cnt - base, exp_pulses); end
        $display("multi_release: code=%0d pressed=%b pulses=%0d", key_code, key_pressed, pulse_cnt - base);
    endtask

    task automatic test_reset_mid_scan();
        int base;
        int k;
        bit found;
        k = $urandom_range(0, 19);
        keys = '0;
        keys[k] = 1'b1;
        cycles(170);
        model_apply(keys);
        found = 0;
        for (int i = 0; i < 60; i++) begin
            if (K_ROW === 5'b10111) begin found = 1; break; end
            @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL midreset_row3 got K_ROW=%b want 10111 within 60 cycles", K_ROW); end
        cycles(2);
        RSTN = 1'b0;
        @(negedge clk);
        exp_code = 0;
        exp_pressed = 0;
        exp_multi = 0;
        checks++; if (K_ROW !== 5'b11110) begin errors++; $display("FAIL midreset_krow got %b want 11110", K_ROW); end
        checks++; if (key_code !== 5'd0) begin errors++; $display("FAIL midreset_code got %0d want 0", key_code); end
        checks++; if (key_pressed !== 1'b0) begin errors++; $display("FAIL midreset_level got %b want 0", key_pressed); end
        checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL midreset_multi got %b want 0", multi_key); end
        #1;
        RSTN = 1'b1;
        base = pulse_cnt;
        cycles(170);
        model_apply(keys);
        checks++; if (key_code !== 5'(exp_code)) begin errors++; $display("FAIL midreset_recommit_code got %0d want %0d", key_code, exp_code); end
        checks++; if (key_pressed !== exp_pressed) begin errors++; $display("FAIL midreset_recommit_level got %b want %b", key_pressed, exp_pressed); end
        checks++; if (pulse_cnt - base != exp_pulses) begin errors++; $display("FAIL midreset_pulses got %0d want %0d", pulse_cnt - base, exp_pulses); end
        $display("reset_mid_scan: key %0d recommit code=%0d pulses=%0d", k, key_code, pulse_cnt - base);
    endtask

    task automatic test_random();
        int base;
        int n;
        int a;
        int b;
        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(0, 2);
            a = $urandom_range(0, 19);
            b = (a + 1 + $urandom_range(0, 18)) % 20;
            keys = '0;
            if (n >= 1) keys[a] = 1'b1;
            if (n >= 2) keys[b] = 1'b1;
            base = pulse_cnt;
            cycles(170);
            model_apply(keys);
            checks++; if (key_code !== 5'(exp_code)) begin errors++; $display("FAIL random_code it %0d got %0d want %0d", it, key_code, exp_code); end
            checks++; if (key_pressed !== exp_pressed) begin errors++; $display("FAIL random_level it %0d got %b want %b", it, key_pressed, exp_pressed); end
            checks++; if (multi_key !== exp_multi) begin errors++; $display("FAIL random_multi it %0d got %b want %b", it, multi_key, exp_multi); end
            checks++; if (pulse_cnt - base != exp_pulses) begin errors++; $display("FAIL random_pulses it %0d got %0d want %0d", it, pulse_cnt - base, exp_pulses); end
            $display("random %0d: keys=%05h code=%0d pressed=%b multi=%b pulses=%0d", it, keys, key_code, key_pressed, multi_key, pulse_cnt - base);
        end
    endtask

    task automatic test_pulse_width();
        checks++;
        if (pulse_wide != 0) begin errors++; $display("FAIL pulse_width got %0d multi-cycle pulses want 0", pulse_wide); end
        $display("pulse_width: total pulses=%0d", pulse_cnt);
    endtask

    initial begin
        test_reset();
        test_row_scan();
        test_single_press();
        test_release();
        test_bounce();
        test_multi_key();
        test_reset_mid_scan();
        test_random();
        test_pulse_width();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
